hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide sequencer owning the HI/LO register pair of the multicycle MIPS core.
//  Started by the instruction decoder in EXEC_1 for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Drives the decoder's stall input until the result is committed, so the decoder holds EXEC_1.
//  HI/LO are exposed continuously for MFHI/MFLO via the ALU result mux.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  reset         in   1      synchronous, active-high reset
//  start         in   1      request; sampled only in IDLE
//  op            in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
//  operand_a     in   WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source)
//  operand_b     in   WIDTH  rt value (divisor / multiplier)
//  stall         out  1      hold decoder in current state
//  done          out  1      one-cycle pulse in the cycle HI/LO are written (or dropped on /0)
//  div_by_zero   out  1      one-cycle pulse alongside done when a DIV/DIVU had operand_b == 0
//  hi            out  WIDTH  HI register
//  lo            out  WIDTH  LO register
// BEHAVIOUR
//  - Reset: state=IDLE, hi=0, lo=0, stall=0, done=0, div_by_zero=0, iteration counter=0.
//  - Reset mid-operation aborts: next cycle IDLE, hi/lo=0, no done pulse.
//  - States: IDLE -> RUN (WIDTH cycles) -> FIXUP (1 cycle) -> IDLE.
//  - IDLE + start + op in {MULT,MULTU,DIV,DIVU}: latch |a|,|b| (signed ops) or a,b (unsigned) and
//    the sign flags; counter=0; go RUN. stall is combinational: high in this same cycle.
//  - IDLE + start + MTHI/MTLO: hi (resp. lo) <= operand_a at the edge; stall stays 0; no done.
//  - IDLE + start + op 110/111: ignored, stall 0.
//  - start while not IDLE: ignored (decoder is stalled; op/operands need not be held).
//  - RUN multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
//  - RUN divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
//  - RUN -> FIXUP when counter == WIDTH-1 (exactly WIDTH RUN cycles).
//  - FIXUP: signed sign correction in 2's complement, then write at the closing edge:
//      mult: {hi,lo} <= product, negated if sign(a)^sign(b)
//      div : lo <= quotient (negated if sign(a)^sign(b)); hi <= remainder (sign of dividend)
//    done=1 during FIXUP; new hi/lo visible the following cycle.
//  - stall = (IDLE & start & muldiv op) | RUN | FIXUP  -> high for exactly WIDTH+2 cycles.
//  - Divide by zero: still runs full WIDTH+2 latency; hi/lo NOT written; div_by_zero=1 with done.
//  - Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no flag).
//  - Abs of 0x80000000 treated as unsigned 2^31 (no overflow in magnitude path).
//  - All arithmetic modulo 2^WIDTH per register; no exceptions raised.
// TESTING
//  - MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall high 34 cycles, hi=0xFFFFFFFE lo=0x00000001, done 1 pulse.
//  - MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  - DIVU a=100 b=0 -> 34 stall cycles, div_by_zero+done pulse, hi/lo keep prior values.
//  - MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 back-to-back -> stall never high, hi/lo updated next cycle.
//  - MULT started, reset asserted at RUN cycle 10 -> IDLE next cycle, hi=lo=0, stall 0, no done.
//  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0; second start during RUN ignored, result unchanged.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of
// the multicycle MIPS core. The decoder starts it from EXEC_1 for
// MULT/MULTU/DIV/DIVU/MTHI/MTLO. The unit raises stall until the result is
// committed, so the decoder holds EXEC_1 while the unit works.
//
// Multiply uses shift-add and retires one multiplier bit per cycle.
// Divide uses the restoring method and produces one quotient bit per cycle.
// Both run on operand magnitudes. The sign is applied in a single FIXUP
// cycle before HI/LO are written.
//
// Ports
//   clk          in   1      system clock, all state on the rising edge
//   reset        in   1      synchronous, active-high reset
//   start        in   1      request, sampled only in IDLE
//   op           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                            100 MTHI, 101 MTLO, others no-op
//   operand_a    in   WIDTH  rs value (dividend / multiplicand / MTHI-MTLO src)
//   operand_b    in   WIDTH  rt value (divisor / multiplier)
//   stall        out  1      hold the decoder in its current state
//   done         out  1      one-cycle pulse in the cycle HI/LO are written
//   div_by_zero  out  1      pulse alongside done for a divide by zero
//   hi           out  WIDTH  HI register
//   lo           out  WIDTH  LO register
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    // Magnitude of an operand. The most negative value maps to 2^(WIDTH-1)
    // read as an unsigned number, so the magnitude path never overflows.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v,
                                               input logic             is_signed);
        if (is_signed && v[WIDTH-1]) begin
            mag_f = ~v + ONE_W;
        end else begin
            mag_f = v;
        end
    endfunction

    // Conditional two's-complement negation of a single-width value.
    function automatic logic [WIDTH-1:0] cneg_w_f(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        if (neg) begin
            cneg_w_f = ~v + ONE_W;
        end else begin
            cneg_w_f = v;
        end
    endfunction

    // Conditional two's-complement negation of a double-width product.
    function automatic logic [2*WIDTH-1:0] cneg_2w_f(input logic [2*WIDTH-1:0] v,
                                                     input logic               neg);
        if (neg) begin
            cneg_2w_f = ~v + ONE_2W;
        end else begin
            cneg_2w_f = v;
        end
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 is_div_r;
    logic                 neg_q_r;     // result / quotient sign: sign(a) ^ sign(b)
    logic                 neg_rem_r;   // remainder follows the dividend sign
    logic                 dbz_r;
    logic [WIDTH-1:0]     opnd_r;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     shreg_r;     // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [2*WIDTH-1:0]   acc_r;       // product accumulator
    logic [WIDTH-1:0]     rem_r;       // partial remainder
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 is_muldiv_s;
    logic                 is_signed_s;
    logic                 is_div_s;
    logic                 launch_s;
    logic                 stall_s;
    logic                 done_s;
    logic [WIDTH-1:0]     mul_add_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_acc_nxt_s;
    logic [WIDTH:0]       div_shift_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_rem_nxt_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quot_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    // Opcode decode. MULT/MULTU/DIV/DIVU all have op[2]=0, and op[0]=1 marks the unsigned forms.
    always_comb begin
        is_muldiv_s = (op[2] == 1'b0);
        is_signed_s = (op[0] == 1'b0);
        is_div_s    = (op[1] == 1'b1);
        launch_s    = (state_r == ST_IDLE) && start && is_muldiv_s;
    end

    // FSM next state together with the stall and done outputs. Stall rises in the launch cycle itself.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_nxt_s = ST_RUN;
                    stall_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                stall_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_FIXUP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIXUP: begin
                stall_s     = 1'b1;
                done_s      = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // One shift-add multiply step and one restoring divide step, both built from the current registers.
    always_comb begin
        if (shreg_r[0]) begin
            mul_add_s = opnd_r;
        end else begin
            mul_add_s = ZERO_W;
        end
        mul_sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mul_add_s};
        mul_acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};

        // The remainder stays below the divisor, so the shifted value needs one extra bit.
        div_shift_s = {rem_r, shreg_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        if (div_ge_s) begin
            div_rem_nxt_s = WIDTH'(div_shift_s - {1'b0, opnd_r});
        end else begin
            div_rem_nxt_s = div_shift_s[WIDTH-1:0];
        end
    end

    // Sign correction applied to the magnitude results in FIXUP.
    always_comb begin
        prod_fix_s = cneg_2w_f(acc_r, neg_q_r);
        quot_fix_s = cneg_w_f(shreg_r, neg_q_r);
        rem_fix_s  = cneg_w_f(rem_r, neg_rem_r);
    end

    // State register and RUN iteration counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_RUN) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= CNT_ZERO;
            end
        end
    end

    // Operand capture at launch, then one datapath iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            dbz_r     <= 1'b0;
            opnd_r    <= ZERO_W;
            shreg_r   <= ZERO_W;
            acc_r     <= ZERO_2W;
            rem_r     <= ZERO_W;
        end else if (launch_s) begin
            is_div_r  <= is_div_s;
            neg_q_r   <= is_signed_s & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_rem_r <= is_signed_s & operand_a[WIDTH-1];
            dbz_r     <= is_div_s & (operand_b == ZERO_W);
            acc_r     <= ZERO_2W;
            rem_r     <= ZERO_W;
            if (is_div_s) begin
                opnd_r  <= mag_f(operand_b, is_signed_s);
                shreg_r <= mag_f(operand_a, is_signed_s);
            end else begin
                opnd_r  <= mag_f(operand_a, is_signed_s);
                shreg_r <= mag_f(operand_b, is_signed_s);
            end
        end else if (state_r == ST_RUN) begin
            if (is_div_r) begin
                rem_r   <= div_rem_nxt_s;
                shreg_r <= {shreg_r[WIDTH-2:0], div_ge_s};
            end else begin
                acc_r   <= mul_acc_nxt_s;
                shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            end
        end else begin
            shreg_r <= shreg_r;
        end
    end

    // HI/LO: direct moves from IDLE, and the arithmetic commit at the FIXUP closing edge unless dividing by zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= ZERO_W;
            lo_r <= ZERO_W;
        end else if ((state_r == ST_IDLE) && start && (op == OP_MTHI)) begin
            hi_r <= operand_a;
        end else if ((state_r == ST_IDLE) && start && (op == OP_MTLO)) begin
            lo_r <= operand_a;
        end else if ((state_r == ST_FIXUP) && !dbz_r) begin
            if (is_div_r) begin
                hi_r <= rem_fix_s;
                lo_r <= quot_fix_s;
            end else begin
                hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                lo_r <= prod_fix_s[WIDTH-1:0];
            end
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign stall       = stall_s;
    assign done        = done_s;
    assign div_by_zero = done_s & dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//
// Directed bench for hilo_muldiv_unit (WIDTH = 32). Every expected value is
// a hand-computed constant. Outputs are sampled a few time units after the
// rising edge. Operands are scrambled while the unit is busy, which confirms
// that they are captured at launch.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        stall;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int n_stall;
    int n_done;
    int n_dbz;
    logic done_seen;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one arithmetic op. The task then counts stall, done and div_by_zero
    // cycles until stall drops, bounded to 100 cycles. At iteration 'inject' it
    // raises a second start with a different op.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject,
                          output int ns, output int nd, output int nz);
        ns = 0;
        nd = 0;
        nz = 0;
        step();
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (stall)       ns++;
            if (done)        nd++;
            if (div_by_zero) nz++;
            if (!stall) break;
            step();
            start     = (i == inject);
            op        = OP_MULTU;
            operand_a = ~a ^ 32'(i);
            operand_b = ~b + 32'(i);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = OP_MULT;
        operand_a = 32'h0;
        operand_b = 32'h0;
        step();
        step();
        #1;
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_lo", {32'h0, lo}, 64'h0);
        check("reset_stall", {63'h0, stall}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_dbz", {63'h0, div_by_zero}, 64'h0);
        reset = 1'b0;

        // MULTU of the largest operands.
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, n_stall, n_done, n_dbz);
        check("multu_max_stall", 64'(n_stall), 64'd34);
        check("multu_max_done", 64'(n_done), 64'd1);
        check("multu_max_dbz", 64'(n_dbz), 64'd0);
        check("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // MULT -3 * 7 = -21.
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, n_stall, n_done, n_dbz);
        check("mult_neg_stall", 64'(n_stall), 64'd34);
        check("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // DIV -7 / 2: quotient -3, remainder -1.
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, n_stall, n_done, n_dbz);
        check("div_neg_done", 64'(n_done), 64'd1);
        check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIVU 100 / 0 keeps the previous HI/LO.
        run_op(OP_DIVU, 32'd100, 32'd0, -1, n_stall, n_done, n_dbz);
        check("dbz_stall", 64'(n_stall), 64'd34);
        check("dbz_done", 64'(n_done), 64'd1);
        check("dbz_flag", 64'(n_dbz), 64'd1);
        check("dbz_hilo_kept", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIVU 100 / 7: quotient 14, remainder 2.
        run_op(OP_DIVU, 32'd100, 32'd7, -1, n_stall, n_done, n_dbz);
        check("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
        check("divu_dbz", 64'(n_dbz), 64'd0);

        // DIV 7 / -2: quotient -3, remainder +1.
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, n_stall, n_done, n_dbz);
        check("div_negb_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        // MULT 0x80000000 * 2 = -2^32.
        run_op(OP_MULT, 32'h8000_0000, 32'd2, -1, n_stall, n_done, n_dbz);
        check("mult_minint_hilo", {hi, lo}, 64'hFFFF_FFFF_0000_0000);

        // Back-to-back MTHI then MTLO: stall never rises, and each write lands at its edge.
        step();
        start     = 1'b1;
        op        = OP_MTHI;
        operand_a = 32'h1234_5678;
        #1;
        check("mthi_stall", {63'h0, stall}, 64'h0);
        step();
        op        = OP_MTLO;
        operand_a = 32'h9ABC_DEF0;
        #1;
        check("mtlo_stall", {63'h0, stall}, 64'h0);
        check("mthi_hi", {32'h0, hi}, 64'h0000_0000_1234_5678);
        check("mthi_lo_kept", {32'h0, lo}, 64'h0);
        check("mthi_done", {63'h0, done}, 64'h0);
        step();
        start = 1'b0;
        #1;
        check("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // Reserved op 110 is ignored.
        start     = 1'b1;
        op        = OP_NOP;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h0000_0001;
        #1;
        check("nop_stall", {63'h0, stall}, 64'h0);
        step();
        start = 1'b0;
        #1;
        check("nop_stall_after", {63'h0, stall}, 64'h0);
        check("nop_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // Overflowing DIV, with a second start raised during RUN.
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5, n_stall, n_done, n_dbz);
        check("div_ovf_stall", 64'(n_stall), 64'd34);
        check("div_ovf_done", 64'(n_done), 64'd1);
        check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        check("div_ovf_idle", {63'h0, stall}, 64'h0);

        // Preload HI so that the abort below has something to clear.
        step();
        start     = 1'b1;
        op        = OP_MTHI;
        operand_a = 32'hA5A5_A5A5;
        step();
        start = 1'b0;
        #1;
        check("pre_abort_hi", {32'h0, hi}, 64'h0000_0000_A5A5_A5A5);

        // Reset at RUN cycle 10 of a MULT: unit returns to IDLE, HI/LO are cleared, no done.
        start     = 1'b1;
        op        = OP_MULT;
        operand_a = 32'd5;
        operand_b = 32'd6;
        done_seen = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            done_seen = done_seen | done;
            step();
        end
        #1;
        check("abort_busy", {63'h0, stall}, 64'h1);
        reset = 1'b1;
        step();
        #1;
        check("abort_stall", {63'h0, stall}, 64'h0);
        check("abort_done", {62'h0, done_seen, done}, 64'h0);
        check("abort_hilo", {hi, lo}, 64'h0);
        reset = 1'b0;

        // The unit works normally after the abort.
        run_op(OP_MULTU, 32'd6, 32'd7, -1, n_stall, n_done, n_dbz);
        check("post_abort_stall", 64'(n_stall), 64'd34);
        check("post_abort_hilo", {hi, lo}, 64'h0000_0000_0000_002A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
